// File: rtl/tt_vector_scheduler_if.sv
// Link between the vector scheduler and the tinytester phase sequencer.
// Handshake: tt_control_o[0] rises to request a run, is held until WAIT is seen and
// tt_datain_i captured, then drops; the run is over once tt_state_i returns to IDLE.
interface tt_vector_scheduler_if;
  logic [31:0] tt_control_o;
  logic [31:0] tt_dataout_o;
  logic [31:0] tt_oe_o;
  logic [31:0] tt_datain_i;
  logic [6:0]  tt_state_i;
  logic [2:0]  sched_state;

  modport master (output tt_control_o, tt_dataout_o, tt_oe_o, sched_state,
                  input  tt_datain_i, tt_state_i);
  modport slave  (input  tt_control_o, tt_dataout_o, tt_oe_o, sched_state,
                  output tt_datain_i, tt_state_i);
endinterface

// File: rtl/tt_vector_scheduler.sv
// Buffers test vectors, launches one tinytester run per vector and collects the
// sampled pad words into a first-word-fall-through result FIFO.
module tt_vector_scheduler #(
  parameter int VEC_AW  = 4,
  parameter int RES_AW  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vec_wr_i,
  input  logic [31:0]           vec_dataout_i,
  input  logic [31:0]           vec_oe_i,
  output logic                  vec_full_o,
  output logic [VEC_AW:0]       vec_count_o,
  input  logic                  run_i,
  input  logic [7:0]            gap_i,
  input  logic                  res_rd_i,
  output logic [31:0]           res_data_o,
  output logic                  res_empty_o,
  output logic [RES_AW:0]       res_count_o,
  input  logic                  err_clr_i,
  output logic                  timeout_o,
  output logic                  ovf_o,
  output logic                  busy_o,
  output logic                  done_o,
  tt_vector_scheduler_if.master tt
);
  localparam int VDEPTH = 1 << VEC_AW;
  localparam int RDEPTH = 1 << RES_AW;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [6:0] TT_IDLE = 7'h20;
  localparam logic [6:0] TT_WAIT = 7'h10;

  typedef enum logic [2:0] {S_IDLE, S_START, S_CAPTURE, S_RELEASE, S_GAP} state_t;

  state_t            state_q;
  logic              ctrl_q;
  logic [31:0]       dout_q;
  logic [31:0]       oe_q;
  logic [TW-1:0]     to_cnt_q;
  logic [7:0]        gap_q;
  logic              done_q;
  logic              timeout_q;
  logic              ovf_q;

  logic [31:0]       vdat_mem [VDEPTH];
  logic [31:0]       voe_mem  [VDEPTH];
  logic [VEC_AW-1:0] vwr_q, vrd_q;
  logic [VEC_AW:0]   vcnt_q;
  logic              vec_full, vec_push, vec_pop;

  logic [31:0]       rdat_mem [RDEPTH];
  logic [RES_AW-1:0] rwr_q, rrd_q;
  logic [RES_AW:0]   rcnt_q;
  logic              res_full, res_push, res_pop;

  assign vec_full = (vcnt_q == (VEC_AW+1)'(VDEPTH));
  assign vec_push = vec_wr_i && !vec_full;
  assign vec_pop  = (state_q == S_IDLE) && run_i && (vcnt_q != '0);

  assign res_full = (rcnt_q == (RES_AW+1)'(RDEPTH));
  assign res_push = (state_q == S_CAPTURE) && !res_full;
  assign res_pop  = res_rd_i && (rcnt_q != '0);

  always_ff @(posedge clk) begin
    if (vec_push) begin
      vdat_mem[vwr_q] <= vec_dataout_i;
      voe_mem[vwr_q]  <= vec_oe_i;
    end
    if (res_push) rdat_mem[rwr_q] <= tt.tt_datain_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vwr_q  <= '0;
      vrd_q  <= '0;
      vcnt_q <= '0;
      rwr_q  <= '0;
      rrd_q  <= '0;
      rcnt_q <= '0;
    end else begin
      if (vec_push) vwr_q <= vwr_q + VEC_AW'(1);
      if (vec_pop)  vrd_q <= vrd_q + VEC_AW'(1);
      vcnt_q <= vcnt_q + (VEC_AW+1)'(vec_push) - (VEC_AW+1)'(vec_pop);
      if (res_push) rwr_q <= rwr_q + RES_AW'(1);
      if (res_pop)  rrd_q <= rrd_q + RES_AW'(1);
      rcnt_q <= rcnt_q + (RES_AW+1)'(res_push) - (RES_AW+1)'(res_pop);
    end
  end

  // Clear-then-set ordering lets a same-cycle error event win over err_clr_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 1'b0;
      dout_q    <= '0;
      oe_q      <= '0;
      to_cnt_q  <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (err_clr_i) begin
        timeout_q <= 1'b0;
        ovf_q     <= 1'b0;
      end
      if (vec_wr_i && vec_full) ovf_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (vec_pop) begin
            dout_q   <= vdat_mem[vrd_q];
            oe_q     <= voe_mem[vrd_q];
            ctrl_q   <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (tt.tt_state_i == TT_WAIT) begin
            state_q <= S_CAPTURE;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            ctrl_q    <= 1'b0;
            state_q   <= S_RELEASE;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_CAPTURE: begin
          if (!res_full) begin
            ctrl_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (tt.tt_state_i == TT_IDLE) begin
            if (gap_i != 8'd0) begin
              gap_q   <= gap_i;
              state_q <= S_GAP;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          gap_q <= gap_q - 8'd1;
          if (gap_q == 8'd1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tt.tt_control_o = {31'b0, ctrl_q};
  assign tt.tt_dataout_o = dout_q;
  assign tt.tt_oe_o      = oe_q;
  assign tt.sched_state  = state_q;

  assign vec_full_o  = vec_full;
  assign vec_count_o = vcnt_q;
  assign res_data_o  = rdat_mem[rrd_q];
  assign res_empty_o = (rcnt_q == '0);
  assign res_count_o = rcnt_q;
  assign timeout_o   = timeout_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
endmodule
